// File: rtl/cnt_ctrl_gen_pkg.sv
// Shared definitions for the counter control front end: step FSM encoding
// and default timing constants for the board build and for simulation.
package cnt_ctrl_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_HOLD = 2'd2
  } step_state_e;

  // 100 MHz board clock, 1 Hz count rate, 10 ms debounce window
  localparam int BOARD_CLK_HZ    = 100_000_000;
  localparam int BOARD_TICK_HZ   = 1;
  localparam int BOARD_DB_CYCLES = 1_000_000;

  // Scaled-down values that keep simulation short
  localparam int SIM_CLK_HZ    = 100;
  localparam int SIM_TICK_HZ   = 10;
  localparam int SIM_DB_CYCLES = 4;

endpackage

// File: rtl/cnt_ctrl_gen_if.sv
// Board-facing bundle: raw switch/button inputs and the En/Ud/run controls
// that feed up_downcounter and the run LED.
interface cnt_ctrl_gen_if;

  logic sw_run_raw;
  logic sw_ud_raw;
  logic btn_step_raw;
  logic En;
  logic Ud;
  logic run;

  modport master (
    output sw_run_raw, sw_ud_raw, btn_step_raw,
    input  En, Ud, run
  );

  modport slave (
    input  sw_run_raw, sw_ud_raw, btn_step_raw,
    output En, Ud, run
  );

endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a debouncer: the output only follows the
// input after it has differed for DB_CYCLES consecutive cycles.
module debounce_sync #(
  parameter int   DB_CYCLES = 4,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          stable;
  logic [CW-1:0] cnt;

  // Synchroniser flops reset to the same value as the stable output so a
  // switch already in that position is not seen as a change after reset.
  // NOTE: all state here uses non-blocking assignments so every flop samples
  // pre-edge values; blocking would collapse the synchroniser into one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= RST_VAL;
      sync_q2 <= RST_VAL;
      stable  <= RST_VAL;
      cnt     <= '0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign dout = stable;

endmodule

// File: rtl/cnt_ctrl_gen.sv
// Drives En/Ud of up_downcounter: debounced switches, a prescaled run-mode
// tick and a one-pulse-per-press manual step, merged into a registered En.
module cnt_ctrl_gen
  import cnt_ctrl_gen_pkg::*;
#(
  parameter int CLK_HZ    = BOARD_CLK_HZ,
  parameter int TICK_HZ   = BOARD_TICK_HZ,
  parameter int DB_CYCLES = BOARD_DB_CYCLES
) (
  input logic           clk,
  input logic           rst,
  cnt_ctrl_gen_if.slave bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic          db_run;
  logic          db_ud;
  logic          db_step;
  logic [PW-1:0] presc;
  logic          tick;
  logic          step;
  step_state_e   state;
  step_state_e   state_nxt;

  debounce_sync #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db_run (
    .clk   (clk),
    .rst_n (rst),
    .din   (bus.sw_run_raw),
    .dout  (db_run)
  );

  // Direction defaults to "up" out of reset
  debounce_sync #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_db_ud (
    .clk   (clk),
    .rst_n (rst),
    .din   (bus.sw_ud_raw),
    .dout  (db_ud)
  );

  debounce_sync #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db_step (
    .clk   (clk),
    .rst_n (rst),
    .din   (bus.btn_step_raw),
    .dout  (db_step)
  );

  // Held at zero outside run mode so the first tick is a full period away
  assign tick = db_run && (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (!db_run || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: defaults first so every path assigns state_nxt and step; a missed
  // branch would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    case (state)
      S_IDLE: begin
        if (db_step) begin
          state_nxt = db_run ? S_HOLD : S_FIRE;
        end
      end
      S_FIRE: begin
        step      = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (!db_step) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // tick needs run=1 and S_FIRE is only entered with run=0, so they never overlap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.En <= 1'b0;
    end else begin
      bus.En <= tick | step;
    end
  end

  assign bus.Ud  = db_ud;
  assign bus.run = db_run;

endmodule

// File: tb/tb_cnt_ctrl_gen.sv
// Directed bench for cnt_ctrl_gen with DIV=10 and a 4-cycle debounce window;
// every expected value is hand-derived from the edge count after a stimulus.
module tb_cnt_ctrl_gen;
  import cnt_ctrl_gen_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cnt_ctrl_gen_if bus ();

  cnt_ctrl_gen #(
    .CLK_HZ    (SIM_CLK_HZ),
    .TICK_HZ   (SIM_TICK_HZ),
    .DB_CYCLES (SIM_DB_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Per-window observations, refreshed by step_cycles
  int pulses;
  int first;
  int ud_hi;
  int run_hi;
  int b2b_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 ns after each; 'first' is the 1-based
  // edge index of the first En pulse in the window (0 if none).
  task automatic step_cycles(input int n);
    logic prev;
    pulses = 0;
    first  = 0;
    ud_hi  = 0;
    run_hi = 0;
    prev   = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (bus.En === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
        if (prev) b2b_err++;
      end
      prev = (bus.En === 1'b1);
      if (bus.Ud === 1'b1)  ud_hi++;
      if (bus.run === 1'b1) run_hi++;
    end
  endtask

  initial begin
    int viol;
    int sum_p;
    int sum_ud;

    bus.sw_run_raw   = 1'b0;
    bus.sw_ud_raw    = 1'b0;
    bus.btn_step_raw = 1'b0;

    // 1. Reset held while raw inputs toggle; outputs must stay at reset values
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      bus.sw_run_raw   = i[0];
      bus.sw_ud_raw    = i[1];
      bus.btn_step_raw = ~i[0];
      step_cycles(1);
      viol += pulses + run_hi + (1 - ud_hi);
    end
    check("rst_hold_outputs", viol, 0);
    bus.sw_run_raw   = 1'b0;
    bus.sw_ud_raw    = 1'b0;
    bus.btn_step_raw = 1'b0;
    rst = 1'b1;
    step_cycles(5);
    check("rst_rel_ud_still_1", ud_hi, 5);
    check("rst_rel_no_en_a", pulses, 0);
    step_cycles(1);
    check("rst_rel_ud_fall_at_6", bus.Ud, 0);
    check("rst_rel_run_low", bus.run, 0);
    check("rst_rel_no_en_b", pulses, 0);

    // 2. Free run: run after 6 edges, then one En every 10 cycles
    bus.sw_run_raw = 1'b1;
    step_cycles(5);
    check("run_not_early", run_hi, 0);
    step_cycles(1);
    check("run_rise_at_6", bus.run, 1);
    step_cycles(50);
    check("run_pulse_count", pulses, 5);
    check("run_first_pulse", first, 10);

    // 3. Manual step: one pulse 8 edges after press, nothing on release
    bus.sw_run_raw = 1'b0;
    step_cycles(8);
    check("stop_no_en", pulses, 0);
    check("stop_run_low", bus.run, 0);
    bus.btn_step_raw = 1'b1;
    step_cycles(40);
    check("step_one_pulse", pulses, 1);
    check("step_latency", first, 8);
    bus.btn_step_raw = 1'b0;
    step_cycles(12);
    check("step_release_no_en", pulses, 0);

    // 4. Glitches shorter than the debounce window are ignored
    bus.btn_step_raw = 1'b1;
    step_cycles(3);
    sum_p  = pulses;
    sum_ud = ud_hi;
    bus.btn_step_raw = 1'b0;
    bus.sw_ud_raw    = 1'b1;
    step_cycles(2);
    sum_p  += pulses;
    sum_ud += ud_hi;
    bus.sw_ud_raw = 1'b0;
    step_cycles(15);
    sum_p  += pulses;
    sum_ud += ud_hi;
    check("glitch_no_en", sum_p, 0);
    check("glitch_ud_unchanged", sum_ud, 0);

    // 5. Direction change and button press during run mode
    bus.sw_run_raw = 1'b1;
    bus.sw_ud_raw  = 1'b1;
    step_cycles(5);
    check("run2_not_early", run_hi, 0);
    step_cycles(1);
    check("run2_rise", bus.run, 1);
    check("run2_ud_up", bus.Ud, 1);
    step_cycles(5);
    check("run2_no_early_en", pulses, 0);
    bus.sw_ud_raw = 1'b0;
    step_cycles(5);
    check("ud_held_5", bus.Ud, 1);
    check("ud_seg_pulses", pulses, 1);
    check("ud_seg_first", first, 5);
    step_cycles(1);
    check("ud_fall_at_6", bus.Ud, 0);
    bus.btn_step_raw = 1'b1;
    step_cycles(20);
    check("run_btn_pulses", pulses, 2);
    check("run_btn_first", first, 9);
    bus.btn_step_raw = 1'b0;
    step_cycles(20);
    check("run_rel_pulses", pulses, 2);
    check("run_rel_first", first, 9);

    // 6. Reset with prescaler at 7, then restart from scratch
    step_cycles(6);
    check("pre_rst_no_en", pulses, 0);
    rst = 1'b0;
    #1;
    check("rst_async_en", bus.En, 0);
    check("rst_async_ud", bus.Ud, 1);
    check("rst_async_run", bus.run, 0);
    step_cycles(3);
    check("rst2_hold_en", pulses, 0);
    check("rst2_hold_run", run_hi, 0);
    rst = 1'b1;
    step_cycles(5);
    check("rst2_rel_no_en", pulses, 0);
    check("rst2_rel_run_low", run_hi, 0);
    step_cycles(1);
    check("rst2_run_requal", bus.run, 1);
    check("rst2_ud_fall", bus.Ud, 0);
    step_cycles(10);
    check("rst2_en_count", pulses, 1);
    check("rst2_en_first", first, 10);
    bus.sw_run_raw = 1'b0;
    step_cycles(10);
    check("rst2_stop_no_en", pulses, 0);
    bus.btn_step_raw = 1'b1;
    step_cycles(12);
    check("rst2_fsm_idle_pulse", pulses, 1);
    check("rst2_fsm_latency", first, 8);
    bus.btn_step_raw = 1'b0;
    step_cycles(10);
    check("rst2_release_no_en", pulses, 0);

    check("no_back_to_back_en", b2b_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
